// File: rtl/issue_scheduler.sv
// issue_scheduler: dual-issue front-end scheduler between IF/ID and decode.
// Buffers fetched instruction pairs in an in-order circular queue and issues
// 0, 1 or 2 instructions per cycle under load-use, intra-pair RAW/WAW and
// structural/control pairing rules. Flush discards all buffered state.
// Optional feature: define ISSUE_SCHED_PERF_EN to build the performance
// counters; without it the perf_* ports are tied to zero.
module issue_scheduler #(
    parameter int QDEPTH   = 4,
    parameter int PC_WIDTH = 32,
    parameter int ILEN     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_valid_0,
    input  logic                fetch_valid_1,
    input  logic [PC_WIDTH-1:0] fetch_pc_0,
    input  logic [PC_WIDTH-1:0] fetch_pc_1,
    input  logic [ILEN-1:0]     fetch_instr_0,
    input  logic [ILEN-1:0]     fetch_instr_1,
    output logic                fetch_ready,
    input  logic                flush,
    input  logic                id_ready,
    output logic                issue_valid_0,
    output logic                issue_valid_1,
    output logic [PC_WIDTH-1:0] issue_pc_0,
    output logic [PC_WIDTH-1:0] issue_pc_1,
    output logic [ILEN-1:0]     issue_instr_0,
    output logic [ILEN-1:0]     issue_instr_1,
    output logic                pair_conflict,
    output logic [31:0]         perf_dual_cnt,
    output logic [31:0]         perf_single_cnt,
    output logic [31:0]         perf_lu_stall_cnt
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [PC_WIDTH-1:0] pc_mem  [QDEPTH];
    logic [ILEN-1:0]     ins_mem [QDEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          lu_valid_q, lu_valid_d;
    logic [4:0]    lu_rd_q, lu_rd_d;

    logic [PW-1:0] nx_ptr, wr_slot1;
    logic [ILEN-1:0] h_ins, n_ins;
    logic [6:0]    h_op, n_op;
    logic [4:0]    h_rd, h_rs1, h_rs2, n_rd, n_rs1, n_rs2;
    logic          h_lu, n_lu, pair_rule;
    logic          push_en;
    logic [CW-1:0] n_push, n_pop;

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    assign nx_ptr = rd_ptr_q + PW'(1);
    assign h_ins  = ins_mem[rd_ptr_q];
    assign n_ins  = ins_mem[nx_ptr];
    assign h_op   = h_ins[6:0];
    assign h_rd   = h_ins[11:7];
    assign h_rs1  = h_ins[19:15];
    assign h_rs2  = h_ins[24:20];
    assign n_op   = n_ins[6:0];
    assign n_rd   = n_ins[11:7];
    assign n_rs1  = n_ins[19:15];
    assign n_rs2  = n_ins[24:20];

    // Hazard evaluation and issue decision; depends only on queue/lu state and flush
    always_comb begin
        h_lu = lu_valid_q && (lu_rd_q != 5'd0) && ((lu_rd_q == h_rs1) || (lu_rd_q == h_rs2));
        n_lu = lu_valid_q && (lu_rd_q != 5'd0) && ((lu_rd_q == n_rs1) || (lu_rd_q == n_rs2));
        pair_rule = (is_mem(h_op) && is_mem(n_op))
                 || is_ctrl(h_op) || is_ctrl(n_op)
                 || ((h_rd != 5'd0) && ((h_rd == n_rs1) || (h_rd == n_rs2)))
                 || ((h_rd != 5'd0) && (h_rd == n_rd));
        issue_valid_0 = (count_q != '0) && !flush && !h_lu;
        issue_valid_1 = issue_valid_0 && (count_q >= CW'(2)) && !pair_rule && !n_lu;
        pair_conflict = (count_q >= CW'(2)) && issue_valid_0 && pair_rule;
        fetch_ready   = count_q <= CW'(QDEPTH - 2);
    end

    assign issue_pc_0    = issue_valid_0 ? pc_mem[rd_ptr_q]  : '0;
    assign issue_pc_1    = issue_valid_1 ? pc_mem[nx_ptr]    : '0;
    assign issue_instr_0 = issue_valid_0 ? h_ins             : '0;
    assign issue_instr_1 = issue_valid_1 ? n_ins             : '0;

    // Queue pointer/count and load-use next-state
    always_comb begin
        push_en  = fetch_ready && !flush;
        n_push   = push_en ? (CW'(fetch_valid_0) + CW'(fetch_valid_1)) : '0;
        n_pop    = id_ready ? (CW'(issue_valid_0) + CW'(issue_valid_1)) : '0;
        wr_slot1 = fetch_valid_0 ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = rd_ptr_q + PW'(n_pop);
        wr_ptr_d = wr_ptr_q + PW'(n_push);
        count_d  = count_q + n_push - n_pop;
        lu_valid_d = lu_valid_q;
        lu_rd_d    = lu_rd_q;
        if (id_ready) begin
            // the youngest issued load wins; a pair can never hold two loads
            if (issue_valid_1 && (n_op == OP_LOAD)) begin
                lu_valid_d = 1'b1;
                lu_rd_d    = n_rd;
            end else if (issue_valid_0 && (h_op == OP_LOAD)) begin
                lu_valid_d = 1'b1;
                lu_rd_d    = h_rd;
            end else begin
                lu_valid_d = 1'b0;
            end
        end
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            lu_valid_d = 1'b0;
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            lu_valid_q <= 1'b0;
            lu_rd_q    <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            lu_valid_q <= lu_valid_d;
            lu_rd_q    <= lu_rd_d;
        end
    end

    // Entry storage: compacted in-order write, slot 0 first; never reset
    always_ff @(posedge clk) begin
        if (push_en) begin
            if (fetch_valid_0) begin
                pc_mem[wr_ptr_q]  <= fetch_pc_0;
                ins_mem[wr_ptr_q] <= fetch_instr_0;
            end
            if (fetch_valid_1) begin
                pc_mem[wr_slot1]  <= fetch_pc_1;
                ins_mem[wr_slot1] <= fetch_instr_1;
            end
        end
    end

`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0] dual_q, single_q, lu_stall_q;

    // Performance counters, sampled on cycles where decode accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dual_q     <= '0;
            single_q   <= '0;
            lu_stall_q <= '0;
        end else if (id_ready) begin
            if (issue_valid_0 && issue_valid_1)  dual_q   <= dual_q + 32'd1;
            if (issue_valid_0 && !issue_valid_1) single_q <= single_q + 32'd1;
            if ((count_q != '0) && !flush && h_lu) lu_stall_q <= lu_stall_q + 32'd1;
        end
    end

    assign perf_dual_cnt     = dual_q;
    assign perf_single_cnt   = single_q;
    assign perf_lu_stall_cnt = lu_stall_q;
`else
    assign perf_dual_cnt     = '0;
    assign perf_single_cnt   = '0;
    assign perf_lu_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed self-checking bench for issue_scheduler.
module tb_issue_scheduler;

    localparam logic [6:0] OP   = 7'b0110011;
    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] ST   = 7'b0100011;
    localparam logic [6:0] BR   = 7'b1100011;

`ifdef ISSUE_SCHED_PERF_EN
    localparam logic [31:0] EXP_DUAL = 32'd4, EXP_SINGLE = 32'd9, EXP_LU = 32'd1;
`else
    localparam logic [31:0] EXP_DUAL = 32'd0, EXP_SINGLE = 32'd0, EXP_LU = 32'd0;
`endif

    logic        clk, rst_n;
    logic        fv0, fv1, fetch_ready, flush, id_ready;
    logic [31:0] fpc0, fpc1, fin0, fin1;
    logic        iv0, iv1, pconf;
    logic [31:0] ipc0, ipc1, iin0, iin1;
    logic [31:0] p_dual, p_single, p_lu;

    int n_checks = 0;
    int n_fail   = 0;

    issue_scheduler #(.QDEPTH(4), .PC_WIDTH(32), .ILEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid_0(fv0), .fetch_valid_1(fv1),
        .fetch_pc_0(fpc0), .fetch_pc_1(fpc1),
        .fetch_instr_0(fin0), .fetch_instr_1(fin1),
        .fetch_ready(fetch_ready), .flush(flush), .id_ready(id_ready),
        .issue_valid_0(iv0), .issue_valid_1(iv1),
        .issue_pc_0(ipc0), .issue_pc_1(ipc1),
        .issue_instr_0(iin0), .issue_instr_1(iin1),
        .pair_conflict(pconf),
        .perf_dual_cnt(p_dual), .perf_single_cnt(p_single), .perf_lu_stall_cnt(p_lu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, op};
    endfunction

    task automatic drive(input logic v0, input logic [31:0] p0, input logic [31:0] i0,
                         input logic v1, input logic [31:0] p1, input logic [31:0] i1);
        fv0 = v0; fpc0 = p0; fin0 = i0;
        fv1 = v1; fpc1 = p1; fin1 = i1;
    endtask

    task automatic drive_none();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (iv0 !== 1'b0) begin n_fail++; $display("FAIL rst_iv0 got %0b exp 0", iv0); end
        n_checks++; if (iv1 !== 1'b0) begin n_fail++; $display("FAIL rst_iv1 got %0b exp 0", iv1); end
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_ready got %0b exp 1", fetch_ready); end
        n_checks++; if (pconf !== 1'b0) begin n_fail++; $display("FAIL rst_pair_conflict got %0b exp 0", pconf); end
        n_checks++; if (ipc0 !== 32'h0) begin n_fail++; $display("FAIL rst_pc0 got %h exp 0", ipc0); end
        n_checks++; if (p_dual !== 32'h0) begin n_fail++; $display("FAIL rst_perf_dual got %0d exp 0", p_dual); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_independent_pair();
        @(negedge clk); id_ready = 1'b1;
        drive(1'b1, 32'h100, enc(OP, 1, 2, 3), 1'b1, 32'h104, enc(OP, 4, 5, 6));
        @(negedge clk); drive_none(); #1;
        n_checks++; if (iv0 !== 1'b1) begin n_fail++; $display("FAIL indep_iv0 got %0b exp 1", iv0); end
        n_checks++; if (iv1 !== 1'b1) begin n_fail++; $display("FAIL indep_iv1 got %0b exp 1", iv1); end
        n_checks++; if (ipc0 !== 32'h100) begin n_fail++; $display("FAIL indep_pc0 got %h exp 100", ipc0); end
        n_checks++; if (ipc1 !== 32'h104) begin n_fail++; $display("FAIL indep_pc1 got %h exp 104", ipc1); end
        n_checks++; if (iin1 !== enc(OP, 4, 5, 6)) begin n_fail++; $display("FAIL indep_instr1 got %h exp %h", iin1, enc(OP, 4, 5, 6)); end
        n_checks++; if (pconf !== 1'b0) begin n_fail++; $display("FAIL indep_pair_conflict got %0b exp 0", pconf); end
        @(negedge clk); #1;
        n_checks++; if (iv0 !== 1'b0) begin n_fail++; $display("FAIL indep_empty_iv0 got %0b exp 0", iv0); end
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL indep_fetch_ready got %0b exp 1", fetch_ready); end
    endtask

    task automatic test_raw();
        @(negedge clk);
        drive(1'b1, 32'h200, enc(OP, 5, 1, 2), 1'b1, 32'h204, enc(OP, 6, 5, 3));
        @(negedge clk); drive_none(); #1;
        n_checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h200) begin n_fail++; $display("FAIL raw_c1_slot0 got v=%0b pc=%h exp v=1 pc=200", iv0, ipc0); end
        n_checks++; if (iv1 !== 1'b0 || ipc1 !== 32'h0) begin n_fail++; $display("FAIL raw_c1_slot1 got v=%0b pc=%h exp v=0 pc=0", iv1, ipc1); end
        n_checks++; if (pconf !== 1'b1) begin n_fail++; $display("FAIL raw_pair_conflict got %0b exp 1", pconf); end
        @(negedge clk); #1;
        n_checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h204) begin n_fail++; $display("FAIL raw_c2_slot0 got v=%0b pc=%h exp v=1 pc=204", iv0, ipc0); end
        n_checks++; if (iv1 !== 1'b0 || pconf !== 1'b0) begin n_fail++; $display("FAIL raw_c2_single got v1=%0b pc=%0b exp 0 0", iv1, pconf); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        drive(1'b1, 32'h300, enc(LD, 7, 1, 0), 1'b1, 32'h304, enc(OP, 8, 7, 2));
        @(negedge clk); drive_none(); #1;
        n_checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h300 || iv1 !== 1'b0) begin n_fail++; $display("FAIL lu_load_alone got v0=%0b pc=%h v1=%0b exp 1 300 0", iv0, ipc0, iv1); end
        @(negedge clk); #1;
        n_checks++; if (iv0 !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got %0b exp 0", iv0); end
        n_checks++; if (pconf !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_conflict got %0b exp 0", pconf); end
        @(negedge clk); #1;
        n_checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h304) begin n_fail++; $display("FAIL lu_consumer got v=%0b pc=%h exp v=1 pc=304", iv0, ipc0); end
        n_checks++; if (p_lu !== EXP_LU) begin n_fail++; $display("FAIL lu_perf got %0d exp %0d", p_lu, EXP_LU); end
    endtask

    task automatic test_pairing_rules();
        @(negedge clk);
        drive(1'b1, 32'h400, enc(LD, 7, 1, 0), 1'b1, 32'h404, enc(ST, 0, 10, 9));
        @(negedge clk); drive_none(); #1;
        n_checks++; if (iv0 !== 1'b1 || iv1 !== 1'b0 || pconf !== 1'b1) begin n_fail++; $display("FAIL mem_pair got v0=%0b v1=%0b pc=%0b exp 1 0 1", iv0, iv1, pconf); end
        @(negedge clk); #1;
        n_checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h404) begin n_fail++; $display("FAIL mem_store got v=%0b pc=%h exp v=1 pc=404", iv0, ipc0); end
        @(negedge clk);
        drive(1'b1, 32'h500, enc(BR, 0, 1, 2), 1'b1, 32'h504, enc(OPI, 11, 12, 1));
        @(negedge clk); drive_none(); #1;
        n_checks++; if (iv0 !== 1'b1 || iv1 !== 1'b0 || pconf !== 1'b1) begin n_fail++; $display("FAIL branch_pair got v0=%0b v1=%0b pc=%0b exp 1 0 1", iv0, iv1, pconf); end
        @(negedge clk); #1;
        n_checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h504) begin n_fail++; $display("FAIL branch_next got v=%0b pc=%h exp v=1 pc=504", iv0, ipc0); end
        @(negedge clk);
        drive(1'b1, 32'h600, enc(OPI, 0, 0, 1), 1'b1, 32'h604, enc(OPI, 0, 0, 2));
        @(negedge clk); drive_none(); #1;
        n_checks++; if (iv0 !== 1'b1 || iv1 !== 1'b1 || ipc1 !== 32'h604) begin n_fail++; $display("FAIL x0_dual got v0=%0b v1=%0b pc1=%h exp 1 1 604", iv0, iv1, ipc1); end
        n_checks++; if (pconf !== 1'b0) begin n_fail++; $display("FAIL x0_conflict got %0b exp 0", pconf); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk); id_ready = 1'b0;
        drive(1'b1, 32'h700, enc(OP, 1, 2, 3), 1'b1, 32'h704, enc(OP, 4, 5, 6)); #1;
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0 got %0b exp 1", fetch_ready); end
        @(negedge clk);
        drive(1'b1, 32'h708, enc(OP, 7, 8, 9), 1'b1, 32'h70c, enc(OP, 10, 11, 12)); #1;
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready2 got %0b exp 1", fetch_ready); end
        n_checks++; if (iv0 !== 1'b1 || iv1 !== 1'b1 || ipc0 !== 32'h700) begin n_fail++; $display("FAIL bp_valid_held got v0=%0b v1=%0b pc=%h exp 1 1 700", iv0, iv1, ipc0); end
        @(negedge clk);
        drive(1'b1, 32'h710, enc(OP, 13, 14, 15), 1'b1, 32'h714, enc(OP, 16, 17, 18)); #1;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got %0b exp 0", fetch_ready); end
        @(negedge clk); drive_none(); id_ready = 1'b1; #1;
        n_checks++; if (ipc0 !== 32'h700 || ipc1 !== 32'h704 || iv1 !== 1'b1) begin n_fail++; $display("FAIL bp_drain1 got pc0=%h pc1=%h v1=%0b exp 700 704 1", ipc0, ipc1, iv1); end
        @(negedge clk); #1;
        n_checks++; if (ipc0 !== 32'h708 || ipc1 !== 32'h70c || iv1 !== 1'b1) begin n_fail++; $display("FAIL bp_drain2 got pc0=%h pc1=%h v1=%0b exp 708 70c 1", ipc0, ipc1, iv1); end
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after got %0b exp 1", fetch_ready); end
        @(negedge clk); #1;
        n_checks++; if (iv0 !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra got v=%0b pc=%h exp v=0", iv0, ipc0); end
    endtask

    task automatic test_flush();
        @(negedge clk); id_ready = 1'b0;
        drive(1'b1, 32'h800, enc(OP, 1, 2, 3), 1'b1, 32'h804, enc(OP, 4, 5, 6));
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h808, enc(OPI, 9, 9, 1));
        @(negedge clk);
        drive(1'b1, 32'h80c, enc(OP, 1, 2, 3), 1'b1, 32'h810, enc(OP, 4, 5, 6)); #1;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fl_three_ready got %0b exp 0", fetch_ready); end
        n_checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h800) begin n_fail++; $display("FAIL fl_head got v=%0b pc=%h exp v=1 pc=800", iv0, ipc0); end
        flush = 1'b1; id_ready = 1'b1; #1;
        n_checks++; if (iv0 !== 1'b0 || iv1 !== 1'b0) begin n_fail++; $display("FAIL fl_same_cycle got v0=%0b v1=%0b exp 0 0", iv0, iv1); end
        n_checks++; if (pconf !== 1'b0 || ipc0 !== 32'h0) begin n_fail++; $display("FAIL fl_masked got pc=%0b pc0=%h exp 0 0", pconf, ipc0); end
        @(negedge clk); flush = 1'b0; drive_none(); #1;
        n_checks++; if (iv0 !== 1'b0) begin n_fail++; $display("FAIL fl_empty got %0b exp 0", iv0); end
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready got %0b exp 1", fetch_ready); end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h900, enc(OPI, 13, 14, 1));
        @(negedge clk); drive_none(); #1;
        n_checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h900 || iin0 !== enc(OPI, 13, 14, 1)) begin n_fail++; $display("FAIL fl_slot1_only got v=%0b pc=%h in=%h exp v=1 pc=900", iv0, ipc0, iin0); end
        n_checks++; if (iv1 !== 1'b0) begin n_fail++; $display("FAIL fl_one_entry_v1 got %0b exp 0", iv1); end
        @(negedge clk); #1;
        n_checks++; if (iv0 !== 1'b0) begin n_fail++; $display("FAIL fl_drained got %0b exp 0", iv0); end
        n_checks++; if (p_dual !== EXP_DUAL) begin n_fail++; $display("FAIL perf_dual got %0d exp %0d", p_dual, EXP_DUAL); end
        n_checks++; if (p_single !== EXP_SINGLE) begin n_fail++; $display("FAIL perf_single got %0d exp %0d", p_single, EXP_SINGLE); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); id_ready = 1'b0;
        drive(1'b1, 32'ha00, enc(OP, 1, 2, 3), 1'b1, 32'ha04, enc(OP, 4, 5, 6));
        @(negedge clk); drive_none(); #1;
        n_checks++; if (iv0 !== 1'b1 || ipc0 !== 32'ha00) begin n_fail++; $display("FAIL mid_pre got v=%0b pc=%h exp v=1 pc=a00", iv0, ipc0); end
        #2 rst_n = 1'b0; #1;
        n_checks++; if (iv0 !== 1'b0 || iv1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got v0=%0b v1=%0b exp 0 0", iv0, iv1); end
        n_checks++; if (ipc0 !== 32'h0 || iin0 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data got pc=%h in=%h exp 0 0", ipc0, iin0); end
        n_checks++; if (fetch_ready !== 1'b1 || pconf !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl got rdy=%0b pc=%0b exp 1 0", fetch_ready, pconf); end
        n_checks++; if (p_dual !== 32'h0 || p_single !== 32'h0 || p_lu !== 32'h0) begin n_fail++; $display("FAIL mid_rst_perf got %0d %0d %0d exp 0 0 0", p_dual, p_single, p_lu); end
        @(negedge clk); rst_n = 1'b1; id_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (iv0 !== 1'b0) begin n_fail++; $display("FAIL mid_after got %0b exp 0", iv0); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; id_ready = 1'b0;
        drive_none();
        test_reset();
        test_independent_pair();
        test_raw();
        test_load_use();
        test_pairing_rules();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Dual-issue front-end scheduler between the IF/ID register and the decode stage. It buffers fetched instruction pairs in a small in-order queue and decides each cycle whether to issue 0, 1 or 2 instructions to decode slots 0/1. It applies load-use, intra-pair RAW/WAW and structural/control pairing rules, and flushes on redirect.

## Interface
- QDEPTH, 4: instruction queue entries; power of two, ≥4.
- PC_WIDTH, 32: PC width.
- ILEN, 32: instruction width.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_valid_0 / fetch_valid_1  in  1  fetch slot valid.
- fetch_pc_0 / fetch_pc_1  in  PC_WIDTH  fetch slot PC.
- fetch_instr_0 / fetch_instr_1  in  ILEN  fetch slot instruction.
- fetch_ready  out  1  queue can accept two entries this cycle.
- flush  in  1  redirect/mispredict; discard all buffered state.
- id_ready  in  1  decode can accept issued instructions this cycle.
- issue_valid_0 / issue_valid_1  out  1  slot issues this cycle.
- issue_pc_0 / issue_pc_1  out  PC_WIDTH  issued PC.
- issue_instr_0 / issue_instr_1  out  ILEN  issued instruction.
- pair_conflict  out  1  head+1 present but blocked by a pairing rule.
- perf_dual_cnt, perf_single_cnt, perf_lu_stall_cnt  out  32 each  performance counters.

## Operation
- Queue: circular buffer with rd_ptr/wr_ptr of log2(QDEPTH) bits plus a count of log2(QDEPTH)+1 bits. Pointers wrap modulo QDEPTH.
- Push: happens when fetch_ready && !flush.
  - Valid fetch slots are written compacted in order, slot 0 first.
  - fetch_valid_1 alone writes one entry.
  - Count increases by the number of valid slots.
- fetch_ready = (QDEPTH − count) ≥ 2, using the registered count. Pops in the same cycle do not affect it.
- Predecode per entry, from opcode bits [6:0]:
  - load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111.
  - rd=[11:7], rs1=[19:15], rs2=[24:20].
  - rs1/rs2 are compared conservatively for every opcode. rd=x0 never creates a hazard.
- Load-use register: lu_valid/lu_rd.
  - When id_ready=1, it loads the rd of the youngest load issued this cycle; lu_valid=0 if no load issued.
  - When id_ready=0, it holds its value.
- Slot 0 (head) issues when all hold:
  - count≥1 and !flush.
  - No load-use hit: !(lu_valid && lu_rd≠0 && lu_rd∈{rs1,rs2} of head).
- Slot 1 (head+1) issues when slot 0 issues, count≥2, and none of these rules apply:
  - Both entries are memory ops.
  - Either entry is branch/jal/jalr.
  - Head rd≠0 and head rd ∈ {rs1,rs2} of head+1 (RAW).
  - Head rd≠0 and head rd = head+1 rd (WAW).
  - Load-use hit on head+1.
- pair_conflict = count≥2 && slot-0 eligible && slot 1 blocked by a pairing rule. It is not asserted for load-use on head+1 alone.
- Pop: only when id_ready=1. rd_ptr and count advance by issue_valid_0 + issue_valid_1.
- issue_valid_* is asserted regardless of id_ready; decode samples it only when id_ready=1.
- Flush:
  - issue_valid_* = 0 in the same cycle.
  - The concurrent push is dropped.
  - Next edge: count=0, pointers=0, lu_valid=0.

## Timing
- Fetch-to-issue latency: an entry pushed at edge N can issue in the cycle following edge N (1 cycle minimum).
- No combinational path from fetch_* to issue_* or fetch_ready. The only paths from inputs to issue_valid_* are flush and the queue/lu state.
- Load-use: a load issued at edge N forces a one-cycle bubble for a dependent consumer, which then issues the next cycle.
- Simultaneous push and pop: count_next = count + pushed − popped. Count never exceeds QDEPTH because the ≥2-free rule guarantees room.
- Queue empty: issue_valid_0 = issue_valid_1 = 0. With exactly one entry, only slot 0 may issue.
- Reset (asynchronous, any cycle including mid-operation): count=0, pointers=0, lu_valid=0, perf counters=0.
  - Outputs then read: fetch_ready=1, issue_valid_*=0, pair_conflict=0, issue_pc_*=0, issue_instr_*=0.
  - Entry storage is not cleared; PC/instr outputs are masked to 0 when invalid.

## Configuration
- ISSUE_SCHED_PERF_EN defined: the three 32-bit counters increment on id_ready edges. They wrap at 2^32 and are cleared by reset only, not by flush.
  - perf_dual_cnt: both slots issue.
  - perf_single_cnt: only slot 0 issues.
  - perf_lu_stall_cnt: head blocked solely by load-use.
- ISSUE_SCHED_PERF_EN undefined: no counter flops; perf_* ports tied to 0.

## Test plan
- Independent pair: push add x1,x2,x3 then sub x4,x5,x6 into an empty queue, id_ready=1 -> next cycle issue_valid_0=1 and issue_valid_1=1, correct PCs, pair_conflict=0, count returns to 0.
- Intra-pair RAW: add x5,x1,x2 then add x6,x5,x3 -> cycle 1: slot 0 only, pair_conflict=1; cycle 2: second instruction issues on slot 0.
- Load-use: lw x7,0(x1) issued alone, then add x8,x7,x2 at head -> one cycle with issue_valid_0=0; add issues the following cycle; perf_lu_stall_cnt=1 when the macro is defined.
- Pairing rules: lw followed by sw, and beq followed by addi, each issue singly. x0-destination pair addi x0,x0,1 then addi x0,x0,2 issues dual.
- Backpressure/full: hold id_ready=0 while pushing pairs -> fetch_ready falls after 2 pairs with QDEPTH=4; on release, entries issue in PC order with no loss or duplication.
- Flush/reset: assert flush with 3 entries queued and a concurrent push -> same cycle issue_valid_*=0; next cycle count=0 and fetch_ready=1. Assert rst_n low mid-stream -> all outputs reach reset values immediately.
